// File: rtl/add_pkg.sv
// Shared types and constants for the streaming adder/accumulator.
package add_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  localparam int SAT_WRAP  = 0;
  localparam int SAT_CLAMP = 1;

endpackage

// File: rtl/add_stream_if.sv
// Stream bundle for driving and observing add_stream_acc.
interface add_stream_if #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8,
  parameter int CNT_W = 8
) (
  input logic clk
);
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_acc_en;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_cnt;
  logic             out_ovf;
endinterface

// File: rtl/add_sat_core.sv
// Combinational acc + a + b with carry-out detection and optional clamp.
module add_sat_core
  import add_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8,
  parameter int SAT   = SAT_WRAP
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);
  logic [WIDTH:0] ab;
  logic [ACC_W:0] full;

  always_comb begin
    ab   = {1'b0, a} + {1'b0, b};
    full = {1'b0, acc} + {{(ACC_W - WIDTH){1'b0}}, ab};
    ovf  = full[ACC_W];
    sum  = full[ACC_W-1:0];
    if (SAT == SAT_CLAMP && ovf) begin
      sum = '1;
    end
  end

endmodule

// File: rtl/add_stream_acc.sv
// Valid/ready adder: plain a+b sums or packet accumulation, registered result.
module add_stream_acc
  import add_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8,
  parameter int CNT_W = 8,
  parameter int SAT   = SAT_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_acc_en,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);
  if (ACC_W < WIDTH + 1) begin : g_bad_acc_w
    $error("add_stream_acc: ACC_W must be >= WIDTH+1");
  end

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_ovf_q, out_ovf_d;

  logic             accept;
  logic             in_accum;
  logic [ACC_W-1:0] core_acc;
  logic [ACC_W-1:0] core_sum;
  logic             core_ovf;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf_acc;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign in_accum = (state_q == ACCUM);
  // A beat in IDLE always starts from zero, so plain sums share the adder.
  assign core_acc = in_accum ? acc_q : '0;
  assign cnt_inc  = !in_accum ? CNT_W'(1) :
                    (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign ovf_acc  = (in_accum && ovf_q) || core_ovf;

  add_sat_core #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W),
    .SAT   (SAT)
  ) u_core (
    .acc (core_acc),
    .a   (in_a),
    .b   (in_b),
    .sum (core_sum),
    .ovf (core_ovf)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q && !out_ready;
    out_sum_d   = out_sum_q;
    out_cnt_d   = out_cnt_q;
    out_ovf_d   = out_ovf_q;
    if (accept) begin
      if ((in_accum || in_acc_en) && !in_last) begin
        state_d = ACCUM;
        acc_d   = core_sum;
        cnt_d   = cnt_inc;
        ovf_d   = ovf_acc;
      end else begin
        state_d     = IDLE;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
        out_valid_d = 1'b1;
        out_sum_d   = core_sum;
        out_cnt_d   = cnt_inc;
        out_ovf_d   = ovf_acc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cnt_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cnt_q   <= out_cnt_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cnt   = out_cnt_q;
  assign out_ovf   = out_ovf_q;

endmodule
